// File: rtl/text_cursor_writer.sv
// Button-driven editor for the character buffer: debounces four push-buttons and turns
// each press into write / step / backspace / clear operations on the buffer write port.
module text_cursor_writer #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int ADDR_W          = 10,
    parameter int DATA_W          = 8,
    parameter int DEPTH           = 1024,
    parameter int CHAR_MIN        = 0,
    parameter int CHAR_MAX        = 127,
    parameter int CLEAR_CHAR      = 32,
    parameter bit AUTO_INC        = 1'b1
) (
    input  logic              sys_clk,
    input  logic              sys_resetn,
    input  logic [3:0]        btn,
    output logic              wen,
    output logic [ADDR_W-1:0] write_addr,
    output logic [DATA_W-1:0] write_data,
    output logic [ADDR_W-1:0] cursor,
    output logic [DATA_W-1:0] cur_char,
    output logic              busy
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [DATA_W-1:0] CH_MIN    = DATA_W'(CHAR_MIN);
    localparam logic [DATA_W-1:0] CH_MAX    = DATA_W'(CHAR_MAX);
    localparam logic [DATA_W-1:0] CH_CLEAR  = DATA_W'(CLEAR_CHAR);

    localparam int B_WRITE = 0;
    localparam int B_STEP  = 1;
    localparam int B_BKSP  = 2;
    localparam int B_CLEAR = 3;

    logic [3:0] meta_reg;
    logic [3:0] sync_reg;
    logic [3:0] evt;

    always_ff @(posedge sys_clk) begin
        if (!sys_resetn) begin
            meta_reg <= '0;
            sync_reg <= '0;
        end else begin
            meta_reg <= btn;
            sync_reg <= meta_reg;
        end
    end

    // One debouncer per button; evt pulses for one cycle on an accepted rising level.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_db
            logic [CNT_W-1:0] cnt_reg;
            logic             level_reg;
            logic             evt_reg;

            always_ff @(posedge sys_clk) begin
                if (!sys_resetn) begin
                    cnt_reg   <= '0;
                    level_reg <= 1'b0;
                    evt_reg   <= 1'b0;
                end else begin
                    evt_reg <= 1'b0;
                    if (sync_reg[gi] == level_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        cnt_reg   <= '0;
                        level_reg <= sync_reg[gi];
                        evt_reg   <= sync_reg[gi];
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
            end

            assign evt[gi] = evt_reg;
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;

    state_t            state_reg, state_next;
    logic              wen_reg, wen_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] data_reg, data_next;
    logic [ADDR_W-1:0] cursor_reg, cursor_next;
    logic [DATA_W-1:0] char_reg, char_next;
    logic              busy_reg, busy_next;

    logic [ADDR_W-1:0] cursor_inc;
    logic [ADDR_W-1:0] cursor_dec;
    logic [DATA_W-1:0] char_inc;

    always_ff @(posedge sys_clk) begin
        if (!sys_resetn) begin
            state_reg  <= IDLE;
            wen_reg    <= 1'b0;
            addr_reg   <= '0;
            data_reg   <= '0;
            cursor_reg <= '0;
            char_reg   <= CH_MIN;
            busy_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            wen_reg    <= wen_next;
            addr_reg   <= addr_next;
            data_reg   <= data_next;
            cursor_reg <= cursor_next;
            char_reg   <= char_next;
            busy_reg   <= busy_next;
        end
    end

    // Explicit wrap compares so DEPTH / CHAR_MAX need not match the port widths.
    always_comb begin
        cursor_inc = (cursor_reg == ADDR_LAST) ? '0 : cursor_reg + ADDR_W'(1);
        cursor_dec = (cursor_reg == '0) ? '0 : cursor_reg - ADDR_W'(1);
        char_inc   = (char_reg == CH_MAX) ? CH_MIN : char_reg + DATA_W'(1);
    end

    always_comb begin
        state_next  = state_reg;
        wen_next    = 1'b0;
        addr_next   = addr_reg;
        data_next   = data_reg;
        cursor_next = cursor_reg;
        char_next   = char_reg;
        busy_next   = busy_reg;

        case (state_reg)
            IDLE: begin
                if (evt[B_CLEAR]) begin
                    busy_next   = 1'b1;
                    cursor_next = '0;
                    wen_next    = 1'b1;
                    addr_next   = '0;
                    data_next   = CH_CLEAR;
                    state_next  = CLEAR;
                end else if (evt[B_BKSP]) begin
                    cursor_next = cursor_dec;
                    wen_next    = 1'b1;
                    addr_next   = cursor_dec;
                    data_next   = CH_CLEAR;
                    state_next  = WRITE;
                end else if (evt[B_WRITE]) begin
                    wen_next    = 1'b1;
                    addr_next   = cursor_reg;
                    data_next   = char_reg;
                    cursor_next = cursor_inc;
                    if (AUTO_INC) begin
                        char_next = char_inc;
                    end
                    state_next  = WRITE;
                end else if (evt[B_STEP]) begin
                    char_next = char_inc;
                end
            end
            WRITE: begin
                state_next = IDLE;
            end
            CLEAR: begin
                // addr_reg doubles as the sweep counter; the strobe for it is on now.
                if (addr_reg == ADDR_LAST) begin
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end else begin
                    wen_next  = 1'b1;
                    addr_next = addr_reg + ADDR_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign wen        = wen_reg;
    assign write_addr = addr_reg;
    assign write_data = data_reg;
    assign cursor     = cursor_reg;
    assign cur_char   = char_reg;
    assign busy       = busy_reg;

endmodule

// File: tb/tb_text_cursor_writer.sv
// Scoreboard bench for text_cursor_writer: a small cursor/char model pushes expected
// buffer writes, and a negedge monitor pops and compares every wen strobe.
module tb_text_cursor_writer;

    localparam int DEB     = 4;
    localparam int AW      = 4;
    localparam int DW      = 4;
    localparam int DEPTH   = 8;
    localparam int CH_MIN  = 0;
    localparam int CH_MAX  = 3;
    localparam int CH_CLR  = 9;

    logic          sys_clk;
    logic          sys_resetn;
    logic [3:0]    btn;
    logic          wen;
    logic [AW-1:0] write_addr;
    logic [DW-1:0] write_data;
    logic [AW-1:0] cursor;
    logic [DW-1:0] cur_char;
    logic          busy;

    text_cursor_writer #(
        .DEBOUNCE_CYCLES(DEB),
        .ADDR_W(AW),
        .DATA_W(DW),
        .DEPTH(DEPTH),
        .CHAR_MIN(CH_MIN),
        .CHAR_MAX(CH_MAX),
        .CLEAR_CHAR(CH_CLR),
        .AUTO_INC(1'b1)
    ) dut (
        .sys_clk(sys_clk),
        .sys_resetn(sys_resetn),
        .btn(btn),
        .wen(wen),
        .write_addr(write_addr),
        .write_data(write_data),
        .cursor(cursor),
        .cur_char(cur_char),
        .busy(busy)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  n_compared   = 0;
    int  n_mismatched = 0;
    int  m_cursor     = 0;
    int  m_char       = CH_MIN;

    task automatic check(input string tag, input int obs, input int exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Every strobe outside reset must match the head of the expectation queue.
    always @(negedge sys_clk) begin
        if (sys_resetn && wen) begin
            if (exp_q.size() == 0) begin
                check("spurious_wen", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                $display("write addr=%0d data=%0d (expected %0d/%0d)",
                         write_addr, write_data, mon_e.addr, mon_e.data);
                check("wr_addr", int'(write_addr), mon_e.addr);
                check("wr_data", int'(write_data), mon_e.data);
            end
        end
    end

    function automatic int step_char(input int c);
        return (c == CH_MAX) ? CH_MIN : c + 1;
    endfunction

    task automatic push_wr(input int a, input int d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic expect_write();
        push_wr(m_cursor, m_char);
        m_cursor = (m_cursor == DEPTH - 1) ? 0 : m_cursor + 1;
        m_char   = step_char(m_char);
    endtask

    task automatic expect_bksp();
        if (m_cursor != 0) m_cursor = m_cursor - 1;
        push_wr(m_cursor, CH_CLR);
    endtask

    task automatic expect_clear();
        for (int i = 0; i < DEPTH; i++) push_wr(i, CH_CLR);
        m_cursor = 0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic press(input logic [3:0] mask);
        btn = mask;
        cycles(10);
        btn = 4'b0000;
        cycles(10);
    endtask

    task automatic check_model(input string tag);
        check({tag, "_cursor"}, int'(cursor), m_cursor);
        check({tag, "_char"}, int'(cur_char), m_char);
        check({tag, "_pending"}, exp_q.size(), 0);
    endtask

    task automatic wait_busy(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge sys_clk);
            if (busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("busy_timeout", 0, 1);
    endtask

    task automatic do_reset();
        sys_resetn = 1'b0;
        btn        = 4'b0000;
        cycles(3);
        sys_resetn = 1'b1;
        m_cursor   = 0;
        m_char     = CH_MIN;
        exp_q.delete();
        cycles(2);
    endtask

    bit ok;

    initial begin
        sys_resetn = 1'b0;
        btn        = 4'b0000;
        cycles(3);
        check("rst_wen", int'(wen), 0);
        check("rst_addr", int'(write_addr), 0);
        check("rst_data", int'(write_data), 0);
        check("rst_cursor", int'(cursor), 0);
        check("rst_char", int'(cur_char), CH_MIN);
        check("rst_busy", int'(busy), 0);
        sys_resetn = 1'b1;
        cycles(2);

        // Bounce on write button, then a clean hold: exactly one write.
        expect_write();
        for (int i = 0; i < 10; i++) begin
            btn[0] = ~btn[0];
            cycles(2);
        end
        btn[0] = 1'b1;
        cycles(10);
        btn[0] = 1'b0;
        cycles(10);
        check_model("bounce");

        // Eight writes from a clean start wrap both cursor and character.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            expect_write();
            press(4'b0001);
        end
        check_model("wrap");

        // Backspace at cursor 0, then after two writes.
        do_reset();
        expect_bksp();
        press(4'b0100);
        check_model("bksp0");
        expect_write();
        press(4'b0001);
        expect_write();
        press(4'b0001);
        expect_bksp();
        press(4'b0100);
        check_model("bksp1");

        // Step alone changes the character without writing.
        m_char = step_char(m_char);
        press(4'b0010);
        check_model("step");

        // Full clear: busy and wen together for DEPTH cycles.
        expect_clear();
        btn = 4'b1000;
        wait_busy(ok);
        if (ok) begin
            for (int i = 0; i < DEPTH; i++) begin
                check("clr_busy", int'(busy), 1);
                check("clr_wen", int'(wen), 1);
                @(negedge sys_clk);
            end
            check("clr_end_busy", int'(busy), 0);
            check("clr_end_wen", int'(wen), 0);
        end
        btn = 4'b0000;
        cycles(10);
        check_model("clear");

        // Write and step together: write wins, step is dropped.
        expect_write();
        press(4'b0011);
        check_model("simul");

        // Write pressed while a clear is sweeping is dropped.
        expect_clear();
        btn = 4'b1000;
        wait_busy(ok);
        btn = 4'b1001;
        cycles(20);
        btn = 4'b0000;
        cycles(12);
        check_model("clr_drop");

        // Reset in the middle of a clear.
        expect_clear();
        btn = 4'b1000;
        wait_busy(ok);
        cycles(2);
        sys_resetn = 1'b0;
        btn        = 4'b0000;
        @(negedge sys_clk);
        check("midrst_wen", int'(wen), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_cursor", int'(cursor), 0);
        check("midrst_char", int'(cur_char), CH_MIN);
        cycles(2);
        sys_resetn = 1'b1;
        m_cursor   = 0;
        m_char     = CH_MIN;
        exp_q.delete();
        cycles(12);
        check_model("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
